// File: rtl/cva6_refill_responder.sv
// AXI4 read-only subordinate serving CVA6 cache refill bursts from a single-cycle SRAM.
// One burst at a time; a 2-entry beat buffer plus one in-flight memory response keeps
// the R channel at one beat per cycle under backpressure.
// Optional feature: define CVA6_REFILL_RESP_WRAP_EN to serve WRAP bursts (len 1/3/7/15);
// without it every WRAP burst is answered with SLVERR and no memory access.
module cva6_refill_responder #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ID_WIDTH   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ar_valid_i,
    output logic                  ar_ready_o,
    input  logic [ADDR_WIDTH-1:0] ar_addr_i,
    input  logic [ID_WIDTH-1:0]   ar_id_i,
    input  logic [7:0]            ar_len_i,
    input  logic [2:0]            ar_size_i,
    input  logic [1:0]            ar_burst_i,
    output logic                  r_valid_o,
    input  logic                  r_ready_i,
    output logic [DATA_WIDTH-1:0] r_data_o,
    output logic [ID_WIDTH-1:0]   r_id_o,
    output logic [1:0]            r_resp_o,
    output logic                  r_last_o,
    output logic                  mem_req_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    localparam int unsigned NB       = DATA_WIDTH / 8;
    localparam int unsigned SizeLog2 = $clog2(NB);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StBurst = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;

    localparam logic [1:0] BurstIncr  = 2'b01;
    localparam logic [1:0] BurstWrap  = 2'b10;
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    localparam logic [ADDR_WIDTH-1:0] BeatBytes = ADDR_WIDTH'(NB);
    localparam logic [ADDR_WIDTH-1:0] AlignMask = ~(BeatBytes - ADDR_WIDTH'(1));

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [7:0]            len_q, len_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  inflight_q, inflight_d;
    logic                  inflight_last_q, inflight_last_d;

    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    logic [DATA_WIDTH-1:0] fifo_data_d [2];
    logic [1:0]            fifo_resp_q [2];
    logic [1:0]            fifo_resp_d [2];
    logic                  fifo_last_q [2];
    logic                  fifo_last_d [2];
    logic                  rd_ptr_q, rd_ptr_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic [1:0]            count_q, count_d;

    logic                  ar_hs;
    logic                  ar_err;
    logic                  issue;
    logic                  issue_last;
    logic [1:0]            pending;
    logic                  fifo_empty;
    logic                  pop;
    logic                  fifo_pop;
    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;
    logic [1:0]            push_resp;
    logic                  push_last;
    logic [ADDR_WIDTH-1:0] addr_inc;
    logic [ADDR_WIDTH-1:0] addr_nxt;

`ifdef CVA6_REFILL_RESP_WRAP_EN
    logic                  wrap_q, wrap_d;
    logic [ADDR_WIDTH-1:0] mask_q, mask_d;
    logic [ADDR_WIDTH-1:0] wrap_mask;
`endif

    // Request acceptance and error classification of the incoming AR
    always_comb begin
        ar_ready_o = (state_q == StIdle) & ~rst_i;
        ar_hs      = ar_valid_i & ar_ready_o;
`ifdef CVA6_REFILL_RESP_WRAP_EN
        wrap_mask  = ((ADDR_WIDTH'(ar_len_i) + ADDR_WIDTH'(1)) << SizeLog2) - ADDR_WIDTH'(1);
        ar_err     = (ar_size_i != 3'(SizeLog2))
                   | ((ar_burst_i != BurstIncr) & (ar_burst_i != BurstWrap))
                   | ((ar_burst_i == BurstWrap) & ~((ar_len_i == 8'd1) | (ar_len_i == 8'd3) |
                                                    (ar_len_i == 8'd7) | (ar_len_i == 8'd15)));
`else
        ar_err     = (ar_size_i != 3'(SizeLog2)) | (ar_burst_i != BurstIncr);
`endif
    end

    // Beat issue: one beat whenever fewer than two are buffered or in flight
    always_comb begin
        pending    = count_q + {1'b0, inflight_q};
        issue      = (state_q == StBurst) & (pending < 2'd2);
        issue_last = (cnt_q == len_q);
        mem_req_o  = issue & ~err_q;
        mem_addr_o = addr_q;
        addr_inc   = addr_q + BeatBytes;
`ifdef CVA6_REFILL_RESP_WRAP_EN
        // High bits stay pinned to the wrap window; low bits roll over inside it
        addr_nxt   = wrap_q ? ((addr_q & ~mask_q) | (addr_inc & mask_q)) : addr_inc;
`else
        addr_nxt   = addr_inc;
`endif
    end

    // R head: FIFO head if any, otherwise the memory response arriving this cycle
    always_comb begin
        fifo_empty = (count_q == 2'd0);
        r_valid_o  = ~fifo_empty | inflight_q;
        r_id_o     = id_q;
        if (!fifo_empty) begin
            r_data_o = fifo_data_q[rd_ptr_q];
            r_resp_o = fifo_resp_q[rd_ptr_q];
            r_last_o = fifo_last_q[rd_ptr_q];
        end else if (inflight_q) begin
            r_data_o = mem_rdata_i;
            r_resp_o = RespOkay;
            r_last_o = inflight_last_q;
        end else begin
            r_data_o = '0;
            r_resp_o = RespOkay;
            r_last_o = 1'b0;
        end
        pop      = r_valid_o & r_ready_i;
        fifo_pop = pop & ~fifo_empty;
    end

    // Beat buffer update; a memory response popped on arrival bypasses the FIFO
    always_comb begin
        push = (inflight_q & ~(fifo_empty & pop)) | (issue & err_q);
        if (inflight_q) begin
            push_data = mem_rdata_i;
            push_resp = RespOkay;
            push_last = inflight_last_q;
        end else begin
            push_data = '0;
            push_resp = RespSlverr;
            push_last = issue_last;
        end
        fifo_data_d = fifo_data_q;
        fifo_resp_d = fifo_resp_q;
        fifo_last_d = fifo_last_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = push_data;
            fifo_resp_d[wr_ptr_q] = push_resp;
            fifo_last_d[wr_ptr_q] = push_last;
        end
        wr_ptr_d        = wr_ptr_q ^ push;
        rd_ptr_d        = rd_ptr_q ^ fifo_pop;
        count_d         = count_q + 2'(push) - 2'(fifo_pop);
        inflight_d      = mem_req_o;
        inflight_last_d = issue_last;
    end

    // Burst FSM and per-burst context
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        id_d    = id_q;
        len_d   = len_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
`ifdef CVA6_REFILL_RESP_WRAP_EN
        wrap_d  = wrap_q;
        mask_d  = mask_q;
`endif
        case (state_q)
            StIdle: begin
                if (ar_hs) begin
                    addr_d  = ar_addr_i & AlignMask;
                    id_d    = ar_id_i;
                    len_d   = ar_len_i;
                    err_d   = ar_err;
                    cnt_d   = '0;
`ifdef CVA6_REFILL_RESP_WRAP_EN
                    wrap_d  = (ar_burst_i == BurstWrap);
                    mask_d  = wrap_mask;
`endif
                    state_d = StBurst;
                end
            end
            StBurst: begin
                if (issue) begin
                    cnt_d  = cnt_q + 8'd1;
                    addr_d = addr_nxt;
                    if (issue_last) state_d = StDrain;
                end
            end
            StDrain: begin
                if (pop && r_last_o) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; reset also drops any outstanding memory response
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q         <= StIdle;
            addr_q          <= '0;
            id_q            <= '0;
            len_q           <= '0;
            err_q           <= 1'b0;
            cnt_q           <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_data_q[0]  <= '0;
            fifo_data_q[1]  <= '0;
            fifo_resp_q[0]  <= '0;
            fifo_resp_q[1]  <= '0;
            fifo_last_q[0]  <= 1'b0;
            fifo_last_q[1]  <= 1'b0;
            rd_ptr_q        <= 1'b0;
            wr_ptr_q        <= 1'b0;
            count_q         <= '0;
`ifdef CVA6_REFILL_RESP_WRAP_EN
            wrap_q          <= 1'b0;
            mask_q          <= '0;
`endif
        end else begin
            state_q         <= state_d;
            addr_q          <= addr_d;
            id_q            <= id_d;
            len_q           <= len_d;
            err_q           <= err_d;
            cnt_q           <= cnt_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            fifo_data_q     <= fifo_data_d;
            fifo_resp_q     <= fifo_resp_d;
            fifo_last_q     <= fifo_last_d;
            rd_ptr_q        <= rd_ptr_d;
            wr_ptr_q        <= wr_ptr_d;
            count_q         <= count_d;
`ifdef CVA6_REFILL_RESP_WRAP_EN
            wrap_q          <= wrap_d;
            mask_q          <= mask_d;
`endif
        end
    end

endmodule

// File: tb/tb_cva6_refill_responder.sv
// Randomized bench for cva6_refill_responder with a burst-level reference model.
// Memory returns data equal to the word address.
module tb_cva6_refill_responder;

`ifdef CVA6_REFILL_RESP_WRAP_EN
    localparam bit WrapEn = 1'b1;
`else
    localparam bit WrapEn = 1'b0;
`endif

    typedef struct {
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ar_valid = 1'b0;
    logic        ar_ready;
    logic [63:0] ar_addr = '0;
    logic [3:0]  ar_id = '0;
    logic [7:0]  ar_len = '0;
    logic [2:0]  ar_size = 3'd3;
    logic [1:0]  ar_burst = 2'b01;
    logic        r_valid;
    logic        r_ready = 1'b1;
    logic [63:0] r_data;
    logic [3:0]  r_id;
    logic [1:0]  r_resp;
    logic        r_last;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic [63:0] mem_rdata = '0;

    int unsigned tests = 0;
    int unsigned fails = 0;
    int          cyc = 0;

    // Test control (written by the main process only)
    int  rdy_mode = 0;
    int  bp_lo = 32'h7fff_ffff;
    int  bp_hi = 32'h7fff_ffff;
    bit  full_rate = 1'b0;

    // Monitor state (written by the monitor only)
    beat_t       exp_q[$];
    logic [63:0] exp_addr_q[$];
    beat_t       mb;
    bit          burst_open = 1'b0;
    bit          cur_err = 1'b0;
    bit          r_seen = 1'b0;
    bit          m_seen = 1'b0;
    int          ar_cyc = 0;
    int          last_pop_cyc = -1;
    int          cur_len = 0;
    int          pend = 0;
    int          mem_req_total = 0;
    int          stall_total = 0;
    int          burst_pops = 0;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_data;
    logic [1:0]  prev_resp;
    logic        prev_last;
    logic [3:0]  prev_id;

    cva6_refill_responder dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .ar_valid_i (ar_valid),
        .ar_ready_o (ar_ready),
        .ar_addr_i  (ar_addr),
        .ar_id_i    (ar_id),
        .ar_len_i   (ar_len),
        .ar_size_i  (ar_size),
        .ar_burst_i (ar_burst),
        .r_valid_o  (r_valid),
        .r_ready_i  (r_ready),
        .r_data_o   (r_data),
        .r_id_o     (r_id),
        .r_resp_o   (r_resp),
        .r_last_o   (r_last),
        .mem_req_o  (mem_req),
        .mem_addr_o (mem_addr),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-cycle SRAM: data equals address
    always @(posedge clk) if (mem_req) mem_rdata <= mem_addr;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] beat_addr(input logic [63:0] a, input logic [7:0] len,
                                              input logic [1:0] burst, input int i);
        logic [63:0] base, lin, mask;
        base = a & ~64'd7;
        lin  = base + 64'(i) * 64'd8;
        if (burst == 2'b10) begin
            mask = (64'(len) + 64'd1) * 64'd8 - 64'd1;
            return (base & ~mask) | (lin & mask);
        end
        return lin;
    endfunction

    function automatic bit model_err(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [7:0] len);
        if (size != 3'd3) return 1'b1;
        if (burst == 2'b01) return 1'b0;
        if (burst == 2'b10 && WrapEn)
            return !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
        return 1'b1;
    endfunction

    // R ready pattern: 0 = always, 1 = random, 2 = low inside [bp_lo, bp_hi]
    always begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            1:       r_ready = ($urandom_range(0, 3) != 0);
            2:       r_ready = !(cyc >= bp_lo && cyc <= bp_hi);
            default: r_ready = 1'b1;
        endcase
    end

    // Monitor and scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            check_eq("rst_ar_ready", ar_ready, 0);
            check_eq("rst_r_valid", r_valid, 0);
            check_eq("rst_mem_req", mem_req, 0);
            check_eq("rst_r_last", r_last, 0);
            check_eq("rst_r_resp", r_resp, 0);
            check_eq("rst_r_data", r_data, 0);
            check_eq("rst_r_id", r_id, 0);
            exp_q.delete();
            exp_addr_q.delete();
            burst_open = 1'b0;
            pend = 0;
            prev_stall = 1'b0;
        end else begin
            if (burst_open) check_eq("ar_ready_busy", ar_ready, 0);
            if (prev_stall) begin
                check_eq("stable_valid", r_valid, 1);
                check_eq("stable_data", r_data, prev_data);
                check_eq("stable_resp", r_resp, prev_resp);
                check_eq("stable_last", r_last, prev_last);
                check_eq("stable_id", r_id, prev_id);
            end
            if (mem_req) begin
                mem_req_total++;
                if (!m_seen && burst_open) begin
                    check_eq("mem_req_latency", cyc - ar_cyc, 1);
                    m_seen = 1'b1;
                end
                check_eq("mem_pending_lt2", pend < 2, 1);
                if (exp_addr_q.size() == 0) check_eq("mem_req_unexpected", 1, 0);
                else check_eq("mem_addr", mem_addr, exp_addr_q.pop_front());
            end
            if (r_valid && !r_seen && burst_open) begin
                check_eq("r_valid_latency", cyc - ar_cyc, 2);
                r_seen = 1'b1;
            end
            if (r_valid && r_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("r_unexpected", 1, 0);
                end else begin
                    mb = exp_q.pop_front();
                    burst_pops++;
                    check_eq("r_data", r_data, mb.data);
                    check_eq("r_resp", r_resp, mb.resp);
                    check_eq("r_last", r_last, mb.last);
                    check_eq("r_id", r_id, mb.id);
                    if (mb.last) begin
                        check_eq("mem_missing", exp_addr_q.size(), 0);
                        if (full_rate) check_eq("throughput", cyc, ar_cyc + 2 + cur_len);
                        burst_open = 1'b0;
                        last_pop_cyc = cyc;
                    end
                end
            end
            if (mem_req) pend++;
            if (r_valid && r_ready && !cur_err) pend--;
            if (r_valid && !r_ready) stall_total++;
            prev_stall = r_valid && !r_ready;
            prev_data = r_data;
            prev_resp = r_resp;
            prev_last = r_last;
            prev_id = r_id;
            if (ar_valid && ar_ready) begin
                check_eq("turnaround", cyc > last_pop_cyc, 1);
                cur_err = model_err(ar_size, ar_burst, ar_len);
                cur_len = int'(ar_len);
                for (int i = 0; i <= int'(ar_len); i++) begin
                    logic [63:0] a;
                    a = beat_addr(ar_addr, ar_len, ar_burst, i);
                    mb.data = cur_err ? 64'd0 : a;
                    mb.resp = cur_err ? 2'b10 : 2'b00;
                    mb.last = (i == int'(ar_len));
                    mb.id   = ar_id;
                    exp_q.push_back(mb);
                    if (!cur_err) exp_addr_q.push_back(a);
                end
                burst_open = 1'b1;
                ar_cyc = cyc;
                r_seen = 1'b0;
                m_seen = 1'b0;
                pend = 0;
                burst_pops = 0;
            end
        end
    end

    // Present an AR and hold it until accepted; returns at posedge+1
    task automatic send_ar(input logic [63:0] a, input logic [3:0] id, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        bit done;
        done = 1'b0;
        ar_addr = a;
        ar_id = id;
        ar_len = len;
        ar_size = size;
        ar_burst = burst;
        ar_valid = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (ar_ready) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) check_eq("ar_timeout", 0, 1);
        @(posedge clk);
        #1;
        ar_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit done;
        done = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (!burst_open && exp_q.size() == 0) begin
                done = 1'b0 | 1'b1;
                break;
            end
        end
        if (!done) check_eq("burst_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("ar_ready_after_reset", ar_ready, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base_req;
        int base_stall;
        bit ok;
        logic [63:0] ra;
        logic [7:0]  rl;
        logic [2:0]  rs;
        logic [1:0]  rb;
        int          sel;

        @(posedge clk);
        #1;
        do_reset(3);

        // INCR len=1 at full rate
        full_rate = 1'b1;
        base_req = mem_req_total;
        send_ar(64'h8000_0010, 4'd5, 8'd1, 3'd3, 2'b01);
        wait_done(50);
        check_eq("incr_mem_reqs", mem_req_total - base_req, 2);

        // WRAP len=3
        base_req = mem_req_total;
        send_ar(64'h8000_0028, 4'd9, 8'd3, 3'd3, 2'b10);
        wait_done(50);
        check_eq("wrap_mem_reqs", mem_req_total - base_req, WrapEn ? 4 : 0);

        // INCR len=7 at full rate
        send_ar(64'hffff_ffff_ffff_ffe0, 4'd1, 8'd7, 3'd3, 2'b01);
        wait_done(50);
        full_rate = 1'b0;

        // Backpressure window T+3 .. T+8
        rdy_mode = 2;
        base_stall = stall_total;
        send_ar(64'h1000_0100, 4'd2, 8'd7, 3'd3, 2'b01);
        bp_lo = ar_cyc + 3;
        bp_hi = ar_cyc + 8;
        wait_done(100);
        check_eq("bp_stall_cycles", stall_total - base_stall, 6);
        rdy_mode = 0;
        bp_lo = 32'h7fff_ffff;
        bp_hi = 32'h7fff_ffff;

        // Bad size
        base_req = mem_req_total;
        send_ar(64'h2000_0000, 4'd3, 8'd2, 3'd2, 2'b01);
        wait_done(50);
        check_eq("badsize_mem_reqs", mem_req_total - base_req, 0);

        // Reset during beat 2 of a len=3 burst
        send_ar(64'h4000_0000, 4'd6, 8'd3, 3'd3, 2'b01);
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (burst_pops >= 1) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("reset_reached_beat2", ok, 1);
        @(posedge clk);
        #1;
        do_reset(2);
        send_ar(64'h4000_1000, 4'd7, 8'd3, 3'd3, 2'b01);
        wait_done(50);

        // Back-to-back: second AR held during the first burst
        send_ar(64'h5000_0000, 4'd8, 8'd3, 3'd3, 2'b01);
        send_ar(64'h5000_0040, 4'd10, 8'd2, 3'd3, 2'b01);
        check_eq("b2b_turnaround", ar_cyc - last_pop_cyc, 1);
        wait_done(50);

        // Randomized bursts with random R backpressure
        rdy_mode = 1;
        for (int n = 0; n < 60; n++) begin
            ra = {$urandom, $urandom};
            sel = $urandom_range(0, 9);
            if (sel <= 5) rb = 2'b01;
            else if (sel <= 8) rb = 2'b10;
            else rb = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
            rs = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'd3;
            if (rb == 2'b10 && $urandom_range(0, 4) != 0) begin
                case ($urandom_range(0, 3))
                    0:       rl = 8'd1;
                    1:       rl = 8'd3;
                    2:       rl = 8'd7;
                    default: rl = 8'd15;
                endcase
            end else begin
                rl = 8'($urandom_range(0, 15));
            end
            send_ar(ra, 4'($urandom), rl, rs, rb);
            if ($urandom_range(0, 1) != 0) wait_done(400);
        end
        wait_done(400);
        rdy_mode = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
